// File: rtl/padovan_datapath.sv
// padovan_datapath: register file, bus muxes and ALU under the Padovan controller.
// Define PADOVAN_DATAPATH_FLAGREG_EN to register the ALU status flags.
module padovan_datapath #(
  parameter int DATAWIDTH     = 8,
  parameter int SELECTIONALU  = 3,
  parameter int SELECTIONDECO = 3
) (
  input  logic                     clk,
  input  logic                     lowRst,
  input  logic [SELECTIONDECO-1:0] sSelDecoA,
  input  logic [SELECTIONDECO-1:0] sSelDecoB,
  input  logic [SELECTIONDECO-1:0] sSelDecoC,
  input  logic [SELECTIONALU-1:0]  sSelAlu,
  input  logic [DATAWIDTH-1:0]     iRegProg0,
  input  logic [DATAWIDTH-1:0]     iRegProg1,
  output logic                     sZero,
  output logic                     sNegative,
  output logic                     sCarry,
  output logic                     sOverflow,
  output logic [DATAWIDTH-1:0]     oResult,
  output logic                     oValid
);

  localparam int NGPR = 5;
  localparam int MSB  = DATAWIDTH - 1;

  logic [DATAWIDTH-1:0] r_gpr [NGPR];
  logic [DATAWIDTH-1:0] r_rp0;
  logic [DATAWIDTH-1:0] r_rp1;
  logic [DATAWIDTH-1:0] r_holdA;
  logic [DATAWIDTH-1:0] r_holdB;
  logic                 r_valid;

  logic [DATAWIDTH-1:0] w_busA;
  logic [DATAWIDTH-1:0] w_busB;
  logic [DATAWIDTH:0]   w_a9;
  logic [DATAWIDTH:0]   w_b9;
  logic [DATAWIDTH:0]   w_wide;
  logic [DATAWIDTH-1:0] w_res;
  logic                 w_carry;
  logic                 w_ovf;
  logic                 w_zero;
  logic                 w_neg;

  // Source mux shared by both read buses; code 7 replays last cycle's bus.
  function automatic logic [DATAWIDTH-1:0] src_sel(
    input logic [SELECTIONDECO-1:0] sel,
    input logic [DATAWIDTH-1:0]     hold
  );
    logic [DATAWIDTH-1:0] v;
    v = '0;
    unique case (sel)
      SELECTIONDECO'(0): v = r_gpr[0];
      SELECTIONDECO'(1): v = r_gpr[1];
      SELECTIONDECO'(2): v = r_gpr[2];
      SELECTIONDECO'(3): v = r_gpr[3];
      SELECTIONDECO'(4): v = r_gpr[4];
      SELECTIONDECO'(5): v = r_rp1;
      SELECTIONDECO'(6): v = r_rp0;
      default:           v = hold;
    endcase
    return v;
  endfunction

  // Read buses see pre-edge register contents.
  always_comb begin
    w_busA = src_sel(sSelDecoA, r_holdA);
    w_busB = src_sel(sSelDecoB, r_holdB);
  end

  // ALU with one extra bit so carry/borrow fall out of the top bit.
  always_comb begin
    w_a9    = {1'b0, w_busA};
    w_b9    = {1'b0, w_busB};
    w_wide  = '0;
    w_carry = 1'b0;
    w_ovf   = 1'b0;
    unique case (sSelAlu)
      SELECTIONALU'(0): w_wide = w_a9;
      SELECTIONALU'(1): begin
        w_wide  = w_a9 - w_b9;
        w_carry = w_wide[DATAWIDTH];
        w_ovf   = (w_busA[MSB] ^ w_busB[MSB])
                & (w_wide[MSB] ^ w_busA[MSB]);
      end
      SELECTIONALU'(2): begin
        w_wide  = w_a9 + w_b9;
        w_carry = w_wide[DATAWIDTH];
        w_ovf   = ~(w_busA[MSB] ^ w_busB[MSB])
                & (w_wide[MSB] ^ w_busA[MSB]);
      end
      SELECTIONALU'(3): w_wide = w_a9 & w_b9;
      SELECTIONALU'(4): w_wide = w_a9 | w_b9;
      SELECTIONALU'(5): w_wide = w_a9 ^ w_b9;
      SELECTIONALU'(6): w_wide = w_b9;
      default:          w_wide = '0;
    endcase
    w_res  = w_wide[MSB:0];
    w_zero = (w_res == '0);
    w_neg  = w_res[MSB];
  end

  // General registers: codes 0-4 write, 5-7 are no-write.
  always_ff @(posedge clk or posedge lowRst) begin
    if (lowRst) begin
      for (int i = 0; i < NGPR; i++) r_gpr[i] <= '0;
    end else begin
      for (int i = 0; i < NGPR; i++) begin
        if (sSelDecoC == SELECTIONDECO'(i)) r_gpr[i] <= w_res;
      end
    end
  end

  // Program registers, bus holds and the R3 write strobe.
  always_ff @(posedge clk or posedge lowRst) begin
    if (lowRst) begin
      r_rp0   <= '0;
      r_rp1   <= '0;
      r_holdA <= '0;
      r_holdB <= '0;
      r_valid <= 1'b0;
    end else begin
      r_rp0   <= iRegProg0;
      r_rp1   <= iRegProg1;
      r_holdA <= w_busA;
      r_holdB <= w_busB;
      r_valid <= (sSelDecoC == SELECTIONDECO'(3));
    end
  end

`ifdef PADOVAN_DATAPATH_FLAGREG_EN
  logic [3:0] r_flags;

  // Flags lag the ALU by one cycle; reset shows a zero result.
  always_ff @(posedge clk or posedge lowRst) begin
    if (lowRst) r_flags <= 4'b1000;
    else        r_flags <= {w_zero, w_neg, w_carry, w_ovf};
  end

  assign {sZero, sNegative, sCarry, sOverflow} = r_flags;
`else
  assign sZero     = w_zero;
  assign sNegative = w_neg;
  assign sCarry    = w_carry;
  assign sOverflow = w_ovf;
`endif

  assign oResult = r_gpr[3];
  assign oValid  = r_valid;

endmodule

// File: tb/tb_padovan_datapath.sv
// tb_padovan_datapath: scoreboard bench for padovan_datapath.
// R3 writes are queued as expected oResult values and popped on oValid.
module tb_padovan_datapath;

  logic       clk = 1'b0;
  logic       lowRst = 1'b0;
  logic [2:0] sSelDecoA = '0;
  logic [2:0] sSelDecoB = '0;
  logic [2:0] sSelDecoC = 3'd7;
  logic [2:0] sSelAlu = '0;
  logic [7:0] iRegProg0 = '0;
  logic [7:0] iRegProg1 = '0;
  logic       sZero, sNegative, sCarry, sOverflow;
  logic [7:0] oResult;
  logic       oValid;

  int total = 0;
  int bad = 0;
  bit run = 1'b0;

  logic [7:0] m_r [5];
  logic [7:0] m_rp0, m_rp1, m_ha, m_hb;
  logic       m_v;
  logic [3:0] m_fl;
  logic [7:0] g_p0 = '0;
  logic [7:0] g_p1 = '0;
  logic [7:0] q[$];

  padovan_datapath dut (
    .clk(clk), .lowRst(lowRst),
    .sSelDecoA(sSelDecoA), .sSelDecoB(sSelDecoB),
    .sSelDecoC(sSelDecoC), .sSelAlu(sSelAlu),
    .iRegProg0(iRegProg0), .iRegProg1(iRegProg1),
    .sZero(sZero), .sNegative(sNegative),
    .sCarry(sCarry), .sOverflow(sOverflow),
    .oResult(oResult), .oValid(oValid)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [3:0] flags();
    return {sZero, sNegative, sCarry, sOverflow};
  endfunction

  function automatic logic [7:0] bus(input logic [2:0] s,
                                     input logic [7:0] h);
    if (s < 3'd5) return m_r[s];
    if (s == 3'd5) return m_rp1;
    if (s == 3'd6) return m_rp0;
    return h;
  endfunction

  // {Z,N,C,V,result}; carry and overflow from integer ranges.
  function automatic logic [11:0] alu(input logic [2:0] op,
                                      input logic [7:0] a,
                                      input logic [7:0] b);
    int ua, ub, sa, sb, sr;
    logic [7:0] r;
    logic c, v;
    ua = int'(a); ub = int'(b);
    sa = int'($signed(a)); sb = int'($signed(b));
    c = 1'b0; v = 1'b0; r = '0;
    case (op)
      3'd0: r = a;
      3'd1: begin
        r = 8'(ua - ub); c = (ua < ub);
        sr = sa - sb; v = (sr > 127) || (sr < -128);
      end
      3'd2: begin
        r = 8'(ua + ub); c = (ua + ub > 255);
        sr = sa + sb; v = (sr > 127) || (sr < -128);
      end
      3'd3: r = a & b;
      3'd4: r = a | b;
      3'd5: r = a ^ b;
      3'd6: r = b;
      default: r = '0;
    endcase
    return {(r == 8'd0), r[7], c, v, r};
  endfunction

  task automatic model_zero();
    for (int i = 0; i < 5; i++) m_r[i] = '0;
    m_rp0 = '0; m_rp1 = '0; m_ha = '0; m_hb = '0;
    m_v = 1'b0; m_fl = 4'b1000;
  endtask

  // One clocked cycle: drive, check flags, advance the model.
  task automatic cyc(input logic [2:0] a, input logic [2:0] b,
                     input logic [2:0] c, input logic [2:0] op);
    logic [7:0] ba, bb;
    logic [11:0] r;
    @(negedge clk);
    sSelDecoA = a; sSelDecoB = b; sSelDecoC = c; sSelAlu = op;
    iRegProg0 = g_p0; iRegProg1 = g_p1;
    lowRst = 1'b0;
    #1;
    ba = bus(a, m_ha);
    bb = bus(b, m_hb);
    r = alu(op, ba, bb);
`ifdef PADOVAN_DATAPATH_FLAGREG_EN
    chk("flags", 32'(flags()), 32'(m_fl));
    m_fl = r[11:8];
`else
    chk("flags", 32'(flags()), 32'(r[11:8]));
`endif
    if (c == 3'd3) q.push_back(r[7:0]);
    if (c < 3'd5) m_r[c] = r[7:0];
    m_ha = ba; m_hb = bb;
    m_rp0 = g_p0; m_rp1 = g_p1;
    m_v = (c == 3'd3);
  endtask

  task automatic settle();
    cyc(3'd7, 3'd7, 3'd7, 3'd7);
  endtask

  // Asynchronous reset in the middle of a cycle; next cyc releases it.
  task automatic do_rst();
    @(negedge clk);
    #2;
    chk("pre_rst_r3", 32'(oResult), 32'(m_r[3]));
    chk("pre_rst_valid", 32'(oValid), 32'(m_v));
    sSelDecoA = '0; sSelDecoB = '0; sSelDecoC = 3'd7; sSelAlu = '0;
    #1 lowRst = 1'b1;
    #1;
    chk("rst_r3", 32'(oResult), 32'd0);
    chk("rst_valid", 32'(oValid), 32'd0);
    chk("rst_flags", 32'(flags()), 32'h8);
    model_zero();
    repeat (2) @(posedge clk);
  endtask

  // Scoreboard: every oValid pulse must match the oldest queued R3 write.
  always @(negedge clk) begin
    if (run && !lowRst && oValid) begin
      if (q.size() == 0) chk("spurious_valid", 32'd1, 32'd0);
      else chk("r3_out", 32'(oResult), 32'(q.pop_front()));
    end
  end

  initial begin
    model_zero();
    #1 lowRst = 1'b1;
    #1;
    chk("init_r3", 32'(oResult), 32'd0);
    chk("init_valid", 32'(oValid), 32'd0);
    chk("init_flags", 32'(flags()), 32'h8);
    run = 1'b1;
    repeat (2) @(posedge clk);

    // seed load and first sum
    g_p0 = 8'd1;
    settle();
    cyc(3'd6, 3'd0, 3'd0, 3'd0);
    cyc(3'd6, 3'd0, 3'd1, 3'd0);
    cyc(3'd6, 3'd0, 3'd2, 3'd0);
    cyc(3'd0, 3'd1, 3'd3, 3'd2);
    settle();
    chk("seed_r3", 32'(oResult), 32'd2);
    cyc(3'd1, 3'd0, 3'd3, 3'd0);
    cyc(3'd2, 3'd0, 3'd3, 3'd0);
    cyc(3'd3, 3'd3, 3'd3, 3'd2);
    cyc(3'd3, 3'd3, 3'd3, 3'd2);
    settle();
    chk("b2b_r3", 32'(oResult), 32'd4);

    // add with carry-out
    g_p0 = 8'd200; g_p1 = 8'd100;
    settle();
    cyc(3'd6, 3'd0, 3'd0, 3'd0);
    cyc(3'd5, 3'd0, 3'd1, 3'd0);
    cyc(3'd0, 3'd1, 3'd3, 3'd2);
    settle();
    chk("add_r3", 32'(oResult), 32'd44);

    // reset mid-sequence with R3=44 and oValid high
    cyc(3'd0, 3'd1, 3'd3, 3'd2);
    g_p0 = '0; g_p1 = '0;
    do_rst();
    for (int k = 0; k < 7; k++) cyc(3'(k), 3'd0, 3'd3, 3'd0);
    settle();

    // hold-bus path
    g_p0 = 8'd12; g_p1 = 8'd12;
    settle();
    cyc(3'd6, 3'd0, 3'd0, 3'd0);
    cyc(3'd5, 3'd0, 3'd7, 3'd0);
    cyc(3'd7, 3'd0, 3'd4, 3'd1);
`ifndef PADOVAN_DATAPATH_FLAGREG_EN
    chk("hold_zero", 32'(sZero), 32'd1);
`endif
    cyc(3'd4, 3'd0, 3'd3, 3'd0);
    settle();
    chk("hold_r4", 32'(oResult), 32'd0);
    g_p0 = 8'd9;
    settle();
    cyc(3'd6, 3'd0, 3'd0, 3'd0);
    cyc(3'd5, 3'd0, 3'd7, 3'd0);
    cyc(3'd7, 3'd0, 3'd4, 3'd1);
    cyc(3'd7, 3'd0, 3'd3, 3'd1);
    settle();
    chk("hold_r3", 32'(oResult), 32'd3);

    // signed overflow and borrow
    g_p0 = 8'h80; g_p1 = 8'h01;
    settle();
    cyc(3'd6, 3'd0, 3'd0, 3'd0);
    cyc(3'd5, 3'd0, 3'd1, 3'd0);
    g_p0 = 8'h02;
    settle();
    cyc(3'd6, 3'd0, 3'd2, 3'd0);
    cyc(3'd0, 3'd1, 3'd3, 3'd1);
`ifndef PADOVAN_DATAPATH_FLAGREG_EN
    chk("sub_ovf", 32'(flags()), 32'h1);
`endif
    settle();
    chk("sub_r3", 32'(oResult), 32'h7f);
    cyc(3'd1, 3'd2, 3'd3, 3'd1);
`ifndef PADOVAN_DATAPATH_FLAGREG_EN
    chk("sub_borrow", 32'(flags()), 32'h6);
`endif
    settle();
    chk("borrow_r3", 32'(oResult), 32'hff);

    // no-write destinations
    cyc(3'd0, 3'd1, 3'd5, 3'd2);
    cyc(3'd0, 3'd1, 3'd6, 3'd2);
    cyc(3'd0, 3'd1, 3'd7, 3'd2);
    for (int k = 0; k < 5; k++) cyc(3'(k), 3'd0, 3'd3, 3'd0);

    // random traffic against the model
    for (int n = 0; n < 400; n++) begin
      g_p0 = 8'($urandom_range(0, 255));
      g_p1 = 8'($urandom_range(0, 255));
      cyc(3'($urandom_range(0, 7)), 3'($urandom_range(0, 7)),
          3'($urandom_range(0, 7)), 3'($urandom_range(0, 7)));
    end
    settle();
    settle();
    chk("queue_empty", 32'(q.size()), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
